// File: rtl/gb_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, IME/EI/DI/RETI handling and
// the five M-cycle dispatch sequence (push PC, clear serviced IF bit, jump to vector).
module gb_interrupt_ctrl #(
  parameter int          NUM_IRQ  = 5,
  parameter logic [15:0] VEC_BASE = 16'h0040
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               m_tick_i,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic [15:0]        bus_addr_i,
  input  logic               bus_we_i,
  input  logic [7:0]         bus_wdata_i,
  output logic [7:0]         bus_rdata_o,
  input  logic               cpu_boundary_i,
  input  logic               cpu_ei_i,
  input  logic               cpu_di_i,
  input  logic               cpu_reti_i,
  input  logic [15:0]        pc_in_i,
  input  logic [15:0]        sp_in_i,
  output logic               ime_o,
  output logic               halt_wake_o,
  output logic               dispatch_busy_o,
  output logic               push_we_o,
  output logic [15:0]        push_addr_o,
  output logic [7:0]         push_data_o,
  output logic               pc_load_o,
  output logic [15:0]        pc_value_o,
  output logic               sp_load_o,
  output logic [15:0]        sp_value_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT1   = 3'd1;
  localparam logic [2:0] S_WAIT2   = 3'd2;
  localparam logic [2:0] S_PUSH_HI = 3'd3;
  localparam logic [2:0] S_PUSH_LO = 3'd4;
  localparam logic [2:0] S_JUMP    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d;
  logic               eip_q, eip_d;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        sp_q, sp_d;
  logic [15:0]        vec_q, vec_d;

  logic [NUM_IRQ-1:0] pending_s;
  logic [NUM_IRQ-1:0] sel_mask_s;
  logic [15:0]        sel_vec_s;
  logic               start_s;
  logic               clr_s;

  // Lowest pending source as a one-hot mask and its vector (0 when nothing pending).
  always_comb begin
    pending_s  = ie_q[NUM_IRQ-1:0] & if_q;
    sel_mask_s = pending_s & (~pending_s + {{(NUM_IRQ-1){1'b0}}, 1'b1});
    sel_vec_s  = 16'h0000;
    for (int i = 0; i < NUM_IRQ; i++) begin
      sel_vec_s = sel_vec_s | ({16{sel_mask_s[i]}} & (VEC_BASE + 16'(8 * i)));
    end
  end

  assign start_s = (state_q == S_IDLE) && m_tick_i && cpu_boundary_i && ime_q && !eip_q
                   && (pending_s != '0);
  assign clr_s   = (state_q == S_PUSH_LO) && m_tick_i;

  // IF/IE next state: bus write, then dispatch clear, then new requests win.
  always_comb begin
    if_d = if_q;
    ie_d = ie_q;
    case ({bus_we_i, bus_addr_i})
      {1'b1, 16'hFF0F}: if_d = bus_wdata_i[NUM_IRQ-1:0];
      {1'b1, 16'hFFFF}: ie_d = bus_wdata_i;
      default:          ie_d = ie_q;
    endcase
    if_d = if_d & ~(sel_mask_s & {NUM_IRQ{clr_s}});
    if_d = if_d | irq_req_i;
  end

  // IME / EI-delay bookkeeping and dispatch FSM.
  always_comb begin
    state_d = state_q;
    ime_d   = ime_q;
    eip_d   = eip_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    vec_d   = vec_q;
    if (m_tick_i) begin
      if (cpu_di_i) begin
        ime_d = 1'b0;
        eip_d = 1'b0;
      end else if (cpu_reti_i) begin
        ime_d = 1'b1;
        eip_d = eip_q | cpu_ei_i;
      end else if (cpu_ei_i) begin
        eip_d = 1'b1;
      end else if (cpu_boundary_i && eip_q) begin
        ime_d = 1'b1;
        eip_d = 1'b0;
      end else begin
        eip_d = eip_q;
      end
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            state_d = S_WAIT1;
            ime_d   = 1'b0;
            pc_d    = pc_in_i;
            sp_d    = sp_in_i;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT1:   state_d = S_WAIT2;
        S_WAIT2:   state_d = S_PUSH_HI;
        S_PUSH_HI: state_d = S_PUSH_LO;
        S_PUSH_LO: begin
          state_d = S_JUMP;
          vec_d   = sel_vec_s;
        end
        S_JUMP:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      if_q    <= '0;
      ie_q    <= 8'h00;
      ime_q   <= 1'b0;
      eip_q   <= 1'b0;
      pc_q    <= 16'h0000;
      sp_q    <= 16'h0000;
      vec_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if_q    <= if_d;
      ie_q    <= ie_d;
      ime_q   <= ime_d;
      eip_q   <= eip_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      vec_q   <= vec_d;
    end
  end

  // Register read mux and stack/PC/SP output drive.
  always_comb begin
    bus_rdata_o = 8'hFF;
    case (bus_addr_i)
      16'hFF0F: bus_rdata_o[NUM_IRQ-1:0] = if_q;
      16'hFFFF: bus_rdata_o = ie_q;
      default:  bus_rdata_o = 8'hFF;
    endcase
    push_we_o   = 1'b0;
    push_addr_o = 16'h0000;
    push_data_o = 8'h00;
    pc_load_o   = 1'b0;
    pc_value_o  = 16'h0000;
    sp_load_o   = 1'b0;
    sp_value_o  = 16'h0000;
    case (state_q)
      S_PUSH_HI: begin
        push_we_o   = m_tick_i;
        push_addr_o = sp_q - 16'd1;
        push_data_o = pc_q[15:8];
      end
      S_PUSH_LO: begin
        push_we_o   = m_tick_i;
        push_addr_o = sp_q - 16'd2;
        push_data_o = pc_q[7:0];
      end
      S_JUMP: begin
        pc_load_o  = m_tick_i;
        pc_value_o = vec_q;
        sp_load_o  = m_tick_i;
        sp_value_o = sp_q - 16'd2;
      end
      default: push_we_o = 1'b0;
    endcase
  end

  assign ime_o           = ime_q;
  assign halt_wake_o     = (pending_s != '0);
  assign dispatch_busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Directed bench for gb_interrupt_ctrl; stack pushes and PC/SP loads are checked
// against a queue of expected events filled when each dispatch is triggered.
module tb_gb_interrupt_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_tick = 1'b0;
  logic [4:0]  irq_req = 5'd0;
  logic [15:0] bus_addr = 16'h0000;
  logic        bus_we = 1'b0;
  logic [7:0]  bus_wdata = 8'h00;
  logic [7:0]  bus_rdata;
  logic        cpu_boundary = 1'b0, cpu_ei = 1'b0, cpu_di = 1'b0, cpu_reti = 1'b0;
  logic [15:0] pc_in = 16'h0000, sp_in = 16'h0000;
  logic        ime, halt_wake, dispatch_busy, push_we, pc_load, sp_load;
  logic [15:0] push_addr, pc_value, sp_value;
  logic [7:0]  push_data;

  int n_vec = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];

  gb_interrupt_ctrl dut (
    .clk_i(clk), .rst_i(rst), .m_tick_i(m_tick), .irq_req_i(irq_req),
    .bus_addr_i(bus_addr), .bus_we_i(bus_we), .bus_wdata_i(bus_wdata), .bus_rdata_o(bus_rdata),
    .cpu_boundary_i(cpu_boundary), .cpu_ei_i(cpu_ei), .cpu_di_i(cpu_di), .cpu_reti_i(cpu_reti),
    .pc_in_i(pc_in), .sp_in_i(sp_in), .ime_o(ime), .halt_wake_o(halt_wake),
    .dispatch_busy_o(dispatch_busy), .push_we_o(push_we), .push_addr_o(push_addr),
    .push_data_o(push_data), .pc_load_o(pc_load), .pc_value_o(pc_value),
    .sp_load_o(sp_load), .sp_value_o(sp_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every strobe clock must match the next queued event.
  always @(negedge clk) begin
    logic [34:0] obs;
    if (push_we || pc_load || sp_load) begin
      obs = push_we ? {3'b100, push_addr, 8'h00, push_data}
                    : {1'b0, pc_load, sp_load, pc_value, sp_value};
      if (exp_q.size() == 0) chk("unexpected_strobe", {29'd0, obs}, 64'd0);
      else chk("stack_event", {29'd0, obs}, {29'd0, exp_q.pop_front()});
    end
  end

  task automatic expect_dispatch(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] vec);
    exp_q.push_back({3'b100, sp - 16'd1, 8'h00, pc[15:8]});
    exp_q.push_back({3'b100, sp - 16'd2, 8'h00, pc[7:0]});
    exp_q.push_back({3'b011, vec, sp - 16'd2});
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic mcycle(input logic bnd, input logic ei, input logic di, input logic reti,
                        input logic [4:0] irq);
    m_tick = 1'b1; cpu_boundary = bnd; cpu_ei = ei; cpu_di = di; cpu_reti = reti; irq_req = irq;
    align();
    m_tick = 1'b0; cpu_boundary = 1'b0; cpu_ei = 1'b0; cpu_di = 1'b0; cpu_reti = 1'b0;
    irq_req = 5'd0;
    align();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) mcycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    align();
    bus_we = 1'b0;
  endtask

  task automatic pulse_irq(input logic [4:0] v);
    irq_req = v;
    align();
    irq_req = 5'd0;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [7:0] expv);
    bus_addr = a;
    #1;
    chk(tag, {56'd0, bus_rdata}, {56'd0, expv});
    align();
  endtask

  initial begin
    repeat (3) align();
    rst = 1'b0;
    align();

    // Reset values, then a pending request with IME off
    rdchk("reset_if", 16'hFF0F, 8'hE0);
    rdchk("reset_ie", 16'hFFFF, 8'h00);
    chk("reset_ime", {63'd0, ime}, 64'd0);
    rdchk("other_addr", 16'hC000, 8'hFF);
    wr(16'hFFFF, 8'h1F);
    pulse_irq(5'b00100);
    rdchk("if_after_irq", 16'hFF0F, 8'hE4);
    chk("halt_wake_ime0", {63'd0, halt_wake}, 64'd1);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("no_dispatch_ime0", {63'd0, dispatch_busy}, 64'd0);

    // Timer dispatch
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h04);
    mcycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    chk("ime_after_reti", {63'd0, ime}, 64'd1);
    pulse_irq(5'b00100);
    pc_in = 16'h1234; sp_in = 16'hFFFE;
    expect_dispatch(16'h1234, 16'hFFFE, 16'h0050);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("busy_after_start", {63'd0, dispatch_busy}, 64'd1);
    chk("ime_cleared_on_entry", {63'd0, ime}, 64'd0);
    pc_in = 16'h5555; sp_in = 16'h6666;
    idle_ticks(5);
    chk("busy_after_jump", {63'd0, dispatch_busy}, 64'd0);
    rdchk("timer_if_cleared", 16'hFF0F, 8'hE0);
    chk("timer_sb_drained", {32'd0, exp_q.size()}, 64'd0);

    // Priority: VBlank beats Joypad
    wr(16'hFFFF, 8'h1F);
    wr(16'hFF0F, 8'h11);
    mcycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    pc_in = 16'h0100; sp_in = 16'hD000;
    expect_dispatch(16'h0100, 16'hD000, 16'h0040);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    idle_ticks(5);
    rdchk("priority_if", 16'hFF0F, 8'hF0);

    // EI delay: first boundary only enables IME, second dispatches Joypad
    mcycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("ei_no_immediate_ime", {63'd0, ime}, 64'd0);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("ei_boundary_ime", {63'd0, ime}, 64'd1);
    chk("ei_boundary_no_dispatch", {63'd0, dispatch_busy}, 64'd0);
    pc_in = 16'h0200; sp_in = 16'hC000;
    expect_dispatch(16'h0200, 16'hC000, 16'h0060);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("ei_second_boundary_dispatch", {63'd0, dispatch_busy}, 64'd1);
    idle_ticks(5);
    rdchk("ei_if_cleared", 16'hFF0F, 8'hE0);

    // Cancellation by IE write during PUSH_HI, with SP wrap-around
    mcycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    pulse_irq(5'b00010);
    pc_in = 16'hABCD; sp_in = 16'h0000;
    expect_dispatch(16'hABCD, 16'h0000, 16'h0000);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    idle_ticks(2);
    wr(16'hFFFF, 8'h00);
    idle_ticks(3);
    rdchk("cancel_if_unchanged", 16'hFF0F, 8'hE2);
    chk("cancel_halt_wake", {63'd0, halt_wake}, 64'd0);

    // Collision: new VBlank request on the PUSH_LO clear clock
    wr(16'hFFFF, 8'h1F);
    wr(16'hFF0F, 8'h00);
    mcycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    pulse_irq(5'b00001);
    pc_in = 16'h0300; sp_in = 16'h8000;
    expect_dispatch(16'h0300, 16'h8000, 16'h0040);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    idle_ticks(3);
    mcycle(1'b0, 1'b0, 1'b0, 1'b0, 5'b00001);
    idle_ticks(1);
    rdchk("collision_if_kept", 16'hFF0F, 8'hE1);
    chk("collision_halt_wake", {63'd0, halt_wake}, 64'd1);

    // Reset while in WAIT2
    mcycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    pc_in = 16'h0400; sp_in = 16'h9000;
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    mcycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("busy_before_reset", {63'd0, dispatch_busy}, 64'd1);
    rst = 1'b1;
    align();
    align();
    rst = 1'b0;
    chk("reset_mid_busy", {63'd0, dispatch_busy}, 64'd0);
    chk("reset_mid_ime", {63'd0, ime}, 64'd0);
    rdchk("reset_mid_if", 16'hFF0F, 8'hE0);
    idle_ticks(4);
    chk("reset_mid_no_push", {63'd0, push_we}, 64'd0);

    // DI beats EI on the same tick
    wr(16'hFFFF, 8'h1F);
    pulse_irq(5'b01000);
    mcycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    mcycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    chk("di_wins_ime", {63'd0, ime}, 64'd0);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("di_wins_no_delayed_ime", {63'd0, ime}, 64'd0);
    chk("di_wins_no_dispatch", {63'd0, dispatch_busy}, 64'd0);

    repeat (4) align();
    chk("sb_empty", {32'd0, exp_q.size()}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gb_interrupt_ctrl.md
# gb_interrupt_ctrl

Game Boy interrupt controller: the requesting side of the CPU's interrupt-flag interface. It owns IF (0xFF0F) and IE (0xFFFF), collects peripheral request pulses, and applies the IME/EI/DI/RETI rules. When an interrupt is taken, it runs the 5 M-cycle dispatch: push PC to the stack, clear the serviced IF bit, load the vector. Sits between the peripherals, the memory bus and the CPU core, which stalls while `dispatch_busy` is high.

## Interface
Parameters:
- NUM_IRQ, 5, number of interrupt sources (bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad)
- VEC_BASE, 16'h0040, vector of bit0; vector(n) = VEC_BASE + 8*n

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_tick  in  1  one-clk strobe per M-cycle; FSM, IME and stack strobes advance only on m_tick
- irq_req  in  NUM_IRQ  request pulses; sampled every clk; set matching IF bits
- bus_addr  in  16  CPU bus address
- bus_we  in  1  write strobe, one clk
- bus_wdata  in  8  write data
- bus_rdata  out  8  read data, combinational
- cpu_boundary  in  1  high with m_tick when the CPU is at an instruction fetch boundary
- cpu_ei / cpu_di / cpu_reti  in  1  each one-clk pulse with m_tick when the instruction executes
- pc_in, sp_in  in  16  current CPU PC and SP
- ime  out  1  interrupt master enable
- halt_wake  out  1  (IE & IF & 5'h1F) != 0, combinational, independent of IME
- dispatch_busy  out  1  high in states WAIT1..JUMP
- push_we  out  1  stack byte write strobe
- push_addr  out  16, push_data  out  8  stack write address/data
- pc_load  out  1, pc_value  out  16  PC overwrite
- sp_load  out  1, sp_value  out  16  SP overwrite

## Operation
- Register access:
  - IF read = {3'b111, if[4:0]}; IE read = ie[7:0]; any other address reads 8'hFF.
  - IF write stores wdata[4:0]; IE write stores all 8 bits.
- IF update order within one clk: bus write, then dispatch clear, then OR in irq_req. A new request always wins over a clear.
- pending = ie[4:0] & if[4:0]; the selected source is the lowest set bit.
- IME rules:
  - cpu_di clears ime and ei_pending immediately.
  - cpu_reti sets ime immediately.
  - cpu_ei sets ei_pending. At the next cpu_boundary, ime<=1 and ei_pending<=0, and no dispatch starts on that boundary. This gives the one-instruction EI delay.
- FSM states: IDLE, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP. One M-cycle per state.
- IDLE -> WAIT1 on m_tick & cpu_boundary & ime & pending!=0. On entry: ime<=0, pc_in and sp_in are latched into pc_q and sp_q.
- WAIT1 -> WAIT2 -> PUSH_HI: idle cycles.
- PUSH_HI: push_addr = sp_q-1, push_data = pc_q[15:8].
- PUSH_LO:
  - push_addr = sp_q-2, push_data = pc_q[7:0].
  - pending is re-evaluated here. The lowest set bit n is selected, if[n] is cleared and the vector is latched as VEC_BASE+8n.
  - If pending==0 here (cancelled by an IE/IF write during PUSH_HI), the vector is 16'h0000 and no IF bit is cleared.
- JUMP: pc_load with pc_value = vector; sp_load with sp_value = sp_q-2. Then -> IDLE.
- Arithmetic is modulo 2^16 (sp_q=0x0000 pushes to 0xFFFF/0xFFFE).
- Reset (including mid-dispatch):
  - FSM -> IDLE; if=0, ie=0, ime=0, ei_pending=0.
  - All strobes 0; pc_value/sp_value/push_addr/push_data = 0.
  - bus_rdata reflects the reset register values (IF reads 8'hE0).

## Timing
- push_we, pc_load and sp_load are single-clk pulses, only on clks where m_tick=1 and the FSM is in the corresponding state.
- Dispatch is 5 M-cycles from the triggering boundary to PC load. The CPU fetches from the vector on the boundary after JUMP.
- irq_req asserted on clk t is visible in bus_rdata and halt_wake at clk t+1.
- A bus write at clk t is visible at t+1.
- cpu_di and cpu_ei on the same tick: cpu_di wins.
- cpu_reti and cpu_ei on the same tick cannot both occur; if they do, ime=1.

## Test plan
- Reset check: after reset, IF read = 8'hE0, IE read = 8'h00. Then write IE=8'h1F and pulse irq_req=5'b00100 with ime=0 -> IF read 8'hE4, halt_wake=1, no dispatch.
- Timer dispatch: ime=1, IE=8'h04, pulse irq_req bit2, pc_in=16'h1234, sp_in=16'hFFFE, boundary -> pushes 8'h12@FFFD then 8'h34@FFFC, pc_value=16'h0050, sp_value=16'hFFFC, IF bit2 cleared, ime=0.
- Priority: IF=5'b10001 and IE=8'h1F at dispatch -> vector 16'h0040, IF read 8'hF0 afterwards.
- EI delay: cpu_ei with pending set -> no dispatch on the next boundary; dispatch starts on the following boundary.
- Cancellation: write IE=8'h00 during PUSH_HI -> pc_value=16'h0000, IF unchanged, sp_value=sp_q-2.
- Collision and reset: irq_req bit0 on the same clk as the PUSH_LO clear of bit0 -> IF bit0 stays 1. Asserting rst in WAIT2 -> dispatch_busy=0, no push_we, ime=0.
